// File: rtl/seg7_scan_driver.sv
// Multiplexed NDIGIT seven-segment scan driver with a tear-free load/commit handshake.
// Optional build macro SEG7_SCAN_GAP_EN adds a two-count dead time at the start of every digit slot.
module seg7_scan_driver #(
    parameter int NDIGIT   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  CLK,
    input  logic                  RSTX,
    input  logic                  LOAD,
    input  logic [4*NDIGIT-1:0]   DIN,
    input  logic [NDIGIT-1:0]     DP_IN,
    input  logic                  HEX,
    input  logic                  LZ_EN,
    output logic                  PEND,
    output logic [6:0]            SEG,
    output logic                  DP,
    output logic [NDIGIT-1:0]     DIG
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NDIGIT);
    localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIGIT - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*NDIGIT-1:0]   shd_din_q, shd_din_d;
    logic [NDIGIT-1:0]     shd_dp_q, shd_dp_d;
    logic                  pend_q, pend_d;
    logic [4*NDIGIT-1:0]   disp_din_q, disp_din_d;
    logic [NDIGIT-1:0]     disp_dp_q, disp_dp_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NDIGIT-1:0]     dig_q, dig_d;

    logic                  presc_tc;
    logic                  frame_end;
    logic                  in_gap;
    logic [3:0]            cur_code;
    logic                  cur_dp;
    logic                  suppress;
    logic [NDIGIT:0]       zero_from;

    function automatic logic [6:0] seg_decode(input logic [3:0] code, input logic hex);
        logic [6:0] s;
        s = 7'b0000000;
        case (code)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = hex ? 7'b1110111 : 7'b0000000;
            4'hB: s = hex ? 7'b1111100 : 7'b0000000;
            4'hC: s = hex ? 7'b0111001 : 7'b0000000;
            4'hD: s = hex ? 7'b1011110 : 7'b0000000;
            4'hE: s = hex ? 7'b1111001 : 7'b0000000;
            default: s = hex ? 7'b1110001 : 7'b0000000;
        endcase
        return s;
    endfunction

    // Scan timing and the shadow/display handshake.
    always_comb begin
        presc_tc  = (presc_q == PRESC_TC);
        frame_end = presc_tc && (idx_q == IDX_LAST);

        presc_d = presc_tc ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_tc) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        shd_din_d  = shd_din_q;
        shd_dp_d   = shd_dp_q;
        disp_din_d = disp_din_q;
        disp_dp_d  = disp_dp_q;
        pend_d     = pend_q;

        // Commit uses the pre-edge shadow, so a coincident LOAD is held for the next frame.
        if (frame_end && pend_q) begin
            disp_din_d = shd_din_q;
            disp_dp_d  = shd_dp_q;
            pend_d     = 1'b0;
        end
        if (LOAD) begin
            shd_din_d = DIN;
            shd_dp_d  = DP_IN;
            pend_d    = 1'b1;
        end
    end

    // Digit selection, leading-zero detection and output decode.
    always_comb begin
        cur_code = 4'h0;
        cur_dp   = 1'b0;
        for (int i = 0; i < NDIGIT; i++) begin
            if (idx_q == IW'(i)) begin
                cur_code = disp_din_q[4*i +: 4];
                cur_dp   = disp_dp_q[i];
            end
        end

        zero_from         = '0;
        zero_from[NDIGIT] = 1'b1;
        for (int i = NDIGIT - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (disp_din_q[4*i +: 4] == 4'h0);
        end

        suppress = 1'b0;
        for (int i = 1; i < NDIGIT; i++) begin
            if (idx_q == IW'(i)) begin
                suppress = LZ_EN && zero_from[i];
            end
        end

`ifdef SEG7_SCAN_GAP_EN
        in_gap = (presc_q == '0) || (presc_q == PW'(1));
`else
        in_gap = 1'b0;
`endif

        dig_d = '0;
        if (!in_gap) begin
            for (int i = 0; i < NDIGIT; i++) begin
                dig_d[i] = (idx_q == IW'(i));
            end
        end
        seg_d = (in_gap || suppress) ? 7'b0000000 : seg_decode(cur_code, HEX);
        dp_d  = in_gap ? 1'b0 : cur_dp;
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            presc_q    <= '0;
            idx_q      <= '0;
            shd_din_q  <= '0;
            shd_dp_q   <= '0;
            pend_q     <= 1'b0;
            disp_din_q <= '0;
            disp_dp_q  <= '0;
            seg_q      <= 7'b0000000;
            dp_q       <= 1'b0;
            dig_q      <= '0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            shd_din_q  <= shd_din_d;
            shd_dp_q   <= shd_dp_d;
            pend_q     <= pend_d;
            disp_din_q <= disp_din_d;
            disp_dp_q  <= disp_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            dig_q      <= dig_d;
        end
    end

    assign PEND = pend_q;
    assign SEG  = seg_q;
    assign DP   = dp_q;
    assign DIG  = dig_q;

endmodule
